mem_arbiter: RTL
================

# mem_arbiter

Two-port arbiter that shares the single-ported 32-bit word memory between the instruction-fetch unit (read-only) and the data load/store unit (read/write). It sits between the core and the memory block. It drives exactly one of the memory's read or write valid/ack channels at a time, and returns read data and a one-cycle done pulse to the winning requester. Its three-state sequencer respects the memory's registered level-ack behaviour.

## Interface
- ADDR_W, 32, word address width (passed unchanged; memory indexes by word)
- DATA_W, 32, data width
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- if_req  in  1  fetch request; held until if_done
- if_addr  in  ADDR_W  fetch word address
- if_rdata  out  DATA_W  fetch read data, valid when if_done=1
- if_done  out  1  one-cycle completion pulse
- dm_req  in  1  data request; held until dm_done
- dm_we  in  1  1 = write, 0 = read
- dm_addr  in  ADDR_W  data word address
- dm_wdata  in  DATA_W  write data
- dm_rdata  out  DATA_W  data read data, valid when dm_done=1
- dm_done  out  1  one-cycle completion pulse
- mem_rd_addr / mem_rd_addr_valid  out  ADDR_W / 1  memory read channel
- mem_rd_data / mem_rd_ack  in  DATA_W / 1  memory read response
- mem_wr_addr / mem_wr_data / mem_wr_data_valid  out  ADDR_W / DATA_W / 1  memory write channel
- mem_wr_ack  in  1  memory write response
- arb_busy  out  1  high whenever state ≠ IDLE

## Operation
- States: IDLE, ISSUE, DRAIN. All outputs are registered.
- IDLE: if any request is pending and both mem acks are 0, grant one port and go to ISSUE. Grant latches the address, write data and we into the mem_* output registers. The matching valid is set to 1: mem_rd_addr_valid for reads and all fetches, mem_wr_data_valid for dm writes.
- ISSUE: hold valid and attributes. On the granted channel's ack=1: clear valid, capture mem_rd_data into the granted port's rdata (reads only), pulse that port's done, go to DRAIN. Acks on the non-granted channel are ignored.
- DRAIN: wait for the granted channel's ack=0. When it drops, arbitrate immediately: go to ISSUE if a request is pending, otherwise go to IDLE.
- At most one of mem_rd_addr_valid and mem_wr_data_valid is high in any cycle.
- Requester attributes are sampled only at grant. Later changes, or dropping req after grant, do not abort the transaction; done still pulses.
- A requester keeping req high the cycle after done is treated as a new request.
- rdata registers hold their value until the next read completion for that port.
- Fetch never writes; there is no if_we.

## Timing
- Reset values: every valid 0, every done 0, arb_busy 0, every addr/data/rdata 0, state IDLE, priority pointer = dm.
- Reset asserted mid-transaction: immediate return to IDLE; the in-flight access is dropped with no done pulse. The first grant after reset waits for both acks to be 0.
- Single access with req high in cycle 0 (IDLE):
  - valid high in cycles 1–2;
  - memory ack seen in cycle 2;
  - done and rdata in cycle 3 (latency 3);
  - ack drops in cycle 4.
- Back-to-back: next valid in cycle 5, so the issue period is 4 cycles.
- Ack stuck high in DRAIN stalls the arbiter indefinitely; no timeout.

## Configuration
- MEM_ARB_RR_EN defined: round-robin. On simultaneous requests the port not served last wins; the pointer updates at each grant; pointer reset value = dm.
- MEM_ARB_RR_EN undefined: fixed priority, dm always wins over if. Fetch can starve under continuous dm traffic.

## Test plan
- Fetch read: memory word 0x10 = 0xDEADBEEF, if_req with if_addr=0x10 in cycle 0 -> mem_rd_addr_valid in cycles 1–2; if_done=1 with if_rdata=0xDEADBEEF in cycle 3 only; arb_busy low again from cycle 5.
- Data write then read: dm_we=1, dm_addr=0x20, dm_wdata=0x12345678 -> mem_wr_data_valid in cycles 1–2, mem_rd_addr_valid never high, dm_done in cycle 3. Then a dm read of 0x20 -> dm_rdata=0x12345678.
- Contention, both requests held from cycle 0:
  - dm served first, dm_done in cycle 3;
  - if served next, if_done in cycle 7;
  - with MEM_ARB_RR_EN and both held continuously, dones alternate dm, if, dm, if.
  - without MEM_ARB_RR_EN, only dm_done pulses while dm_req stays high.
- Attribute stability: change if_addr from 0x10 to 0x30 in cycle 1 -> mem_rd_addr stays 0x10 and returned data is word 0x10.
- Reset mid-ISSUE: assert reset in cycle 2 -> valids, done and arb_busy go to 0 asynchronously with no done pulse. After release the request is reissued and completes correctly.
- Invariant checker, every cycle: mem_rd_addr_valid & mem_wr_data_valid == 0; if_done & dm_done == 0; each done is exactly one cycle wide.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle of every handshake and bus signal around mem_arbiter: the fetch port,
// the data load/store port, the memory read/write channels and arb_busy.
// Modports:
//   slave  - arbiter view (requests and memory responses in; grants and completions out)
//   master - core + memory view (drives requests and memory responses)
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // instruction fetch port (read-only)
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_done;

    // data load/store port
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_done;

    // memory read channel
    logic [ADDR_W-1:0] mem_rd_addr;
    logic              mem_rd_addr_valid;
    logic [DATA_W-1:0] mem_rd_data;
    logic              mem_rd_ack;

    // memory write channel
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [DATA_W-1:0] mem_wr_data;
    logic              mem_wr_data_valid;
    logic              mem_wr_ack;

    logic              arb_busy;

    modport slave (
        input  if_req, if_addr,
        input  dm_req, dm_we, dm_addr, dm_wdata,
        input  mem_rd_data, mem_rd_ack, mem_wr_ack,
        output if_rdata, if_done,
        output dm_rdata, dm_done,
        output mem_rd_addr, mem_rd_addr_valid,
        output mem_wr_addr, mem_wr_data, mem_wr_data_valid,
        output arb_busy
    );

    modport master (
        output if_req, if_addr,
        output dm_req, dm_we, dm_addr, dm_wdata,
        output mem_rd_data, mem_rd_ack, mem_wr_ack,
        input  if_rdata, if_done,
        input  dm_rdata, dm_done,
        input  mem_rd_addr, mem_rd_addr_valid,
        input  mem_wr_addr, mem_wr_data, mem_wr_data_valid,
        input  arb_busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Purpose: shares one single-ported word memory between instruction fetch (read) and data load/store (read/write).
// Latency: request seen in cycle 0 -> valid in cycles 1-2 -> done + rdata in cycle 3; back-to-back issue period 4 cycles.
// Backpressure: requesters hold req until done; the arbiter waits on the memory's level ack rising then falling, no timeout.
//
// Ports: clk, reset (async, active-high), bus (mem_arbiter_if.slave: fetch port, data port,
//        memory read/write channels, arb_busy). All outputs come straight from registers.
// Build option: define MEM_ARB_RR_EN for round-robin between the two ports; otherwise the data
//        port has fixed priority over fetch.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic           clk,
    input logic           reset,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state_q,     state_d;
    logic              gnt_dm_q,    gnt_dm_d;     // 1 = data port owns the transaction
    logic              gnt_we_q,    gnt_we_d;     // 1 = transaction uses the write channel
    logic              rd_vld_q,    rd_vld_d;
    logic              wr_vld_q,    wr_vld_d;
    logic [ADDR_W-1:0] rd_addr_q,   rd_addr_d;
    logic [ADDR_W-1:0] wr_addr_q,   wr_addr_d;
    logic [DATA_W-1:0] wr_data_q,   wr_data_d;
    logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q,  dm_rdata_d;
    logic              if_done_q,   if_done_d;
    logic              dm_done_q,   dm_done_d;
    logic              busy_q,      busy_d;
`ifdef MEM_ARB_RR_EN
    logic              prio_dm_q,   prio_dm_d;    // 1 = data port wins the next tie
`endif

    logic if_pend;
    logic dm_pend;
    logic any_pend;
    logic pick_dm;
    logic gnt_ack;
    logic do_grant;

    // A port's req is still the old transaction's req in its own done cycle;
    // it only counts as a new request from the following cycle on.
    assign if_pend  = bus.if_req & ~if_done_q;
    assign dm_pend  = bus.dm_req & ~dm_done_q;
    assign any_pend = if_pend | dm_pend;

`ifdef MEM_ARB_RR_EN
    assign pick_dm = dm_pend & (~if_pend | prio_dm_q);
`else
    assign pick_dm = dm_pend;
`endif

    // Only the channel carrying the granted access is watched; the other ack is ignored.
    assign gnt_ack = gnt_we_q ? bus.mem_wr_ack : bus.mem_rd_ack;

    always_comb begin
        state_d    = state_q;
        gnt_dm_d   = gnt_dm_q;
        gnt_we_d   = gnt_we_q;
        rd_vld_d   = rd_vld_q;
        wr_vld_d   = wr_vld_q;
        rd_addr_d  = rd_addr_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        if_done_d  = 1'b0;
        dm_done_d  = 1'b0;
`ifdef MEM_ARB_RR_EN
        prio_dm_d  = prio_dm_q;
`endif
        do_grant   = 1'b0;

        case (state_q)
            IDLE: begin
                // Both acks must be low so a stale ack left over from before a
                // reset cannot complete the new access early.
                if (any_pend && !bus.mem_rd_ack && !bus.mem_wr_ack) begin
                    do_grant = 1'b1;
                end
            end
            ISSUE: begin
                if (gnt_ack) begin
                    rd_vld_d = 1'b0;
                    wr_vld_d = 1'b0;
                    state_d  = DRAIN;
                    if (gnt_dm_q) begin
                        dm_done_d = 1'b1;
                        if (!gnt_we_q) begin
                            dm_rdata_d = bus.mem_rd_data;
                        end
                    end else begin
                        if_done_d  = 1'b1;
                        if_rdata_d = bus.mem_rd_data;
                    end
                end
            end
            DRAIN: begin
                // Memory ack is a registered level; wait for it to fall before reuse.
                if (!gnt_ack) begin
                    if (any_pend) begin
                        do_grant = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (do_grant) begin
            state_d  = ISSUE;
            gnt_dm_d = pick_dm;
            gnt_we_d = pick_dm & bus.dm_we;
            if (pick_dm && bus.dm_we) begin
                wr_addr_d = bus.dm_addr;
                wr_data_d = bus.dm_wdata;
                wr_vld_d  = 1'b1;
            end else begin
                rd_addr_d = pick_dm ? bus.dm_addr : bus.if_addr;
                rd_vld_d  = 1'b1;
            end
`ifdef MEM_ARB_RR_EN
            prio_dm_d = ~pick_dm;
`endif
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            gnt_dm_q   <= 1'b0;
            gnt_we_q   <= 1'b0;
            rd_vld_q   <= 1'b0;
            wr_vld_q   <= 1'b0;
            rd_addr_q  <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            if_done_q  <= 1'b0;
            dm_done_q  <= 1'b0;
            busy_q     <= 1'b0;
`ifdef MEM_ARB_RR_EN
            prio_dm_q  <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            gnt_dm_q   <= gnt_dm_d;
            gnt_we_q   <= gnt_we_d;
            rd_vld_q   <= rd_vld_d;
            wr_vld_q   <= wr_vld_d;
            rd_addr_q  <= rd_addr_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
            if_done_q  <= if_done_d;
            dm_done_q  <= dm_done_d;
            busy_q     <= busy_d;
`ifdef MEM_ARB_RR_EN
            prio_dm_q  <= prio_dm_d;
`endif
        end
    end

    assign bus.if_rdata          = if_rdata_q;
    assign bus.if_done           = if_done_q;
    assign bus.dm_rdata          = dm_rdata_q;
    assign bus.dm_done           = dm_done_q;
    assign bus.mem_rd_addr       = rd_addr_q;
    assign bus.mem_rd_addr_valid = rd_vld_q;
    assign bus.mem_wr_addr       = wr_addr_q;
    assign bus.mem_wr_data       = wr_data_q;
    assign bus.mem_wr_data_valid = wr_vld_q;
    assign bus.arb_busy          = busy_q;

endmodule
